// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key decoder.
package morse_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_SPACE,
      S_STUCK
   } state_e;

   localparam logic DOT  = 1'b0;
   localparam logic DASH = 1'b1;

   function automatic int len_w(input int max_sym);
      return $clog2(max_sym + 1);
   endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Character delivery channel: one-entry valid/ready holding register contents.
interface morse_decoder_if #(
   parameter int LEN_W   = 3,
   parameter int MAX_SYM = 5
);
   logic               char_valid;
   logic               char_ready;
   logic [LEN_W-1:0]   char_len;
   logic [MAX_SYM-1:0] char_code;
   logic               char_err;
   logic               match;

   modport master (
      output char_valid, char_len, char_code, char_err, match,
      input  char_ready
   );

   modport slave (
      input  char_valid, char_len, char_code, char_err, match,
      output char_ready
   );
endinterface

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// rise_o/fall_o pulse during the first cycle of the new key_d_o level.
module morse_debounce #(
   parameter int DEBOUNCE = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic key_d_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          key_q, rise_q, fall_q;
   logic          differ, toggle;

   always_comb begin
      differ = sync_q[1] != key_q;
      toggle = differ && (cnt_q == CW'(DEBOUNCE - 1));
      cnt_d  = '0;
      if (differ && !toggle) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
         key_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_i};
         cnt_q  <= cnt_d;
         rise_q <= toggle & ~key_q;
         fall_q <= toggle & key_q;
         if (toggle) key_q <= ~key_q;
      end
   end

   assign key_d_o = key_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: classifies debounced marks into dots/dashes, assembles
// characters, delivers them through a valid/ready holding register and scores matches.
module morse_decoder
   import morse_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int DEBOUNCE = 2,
   parameter int DOT_MIN  = 20,
   parameter int DASH_MIN = 60,
   parameter int CHAR_GAP = 40,
   parameter int MAX_SYM  = 5,
   parameter int LEN_W    = len_w(MAX_SYM)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               key_i,
   input  logic [LEN_W-1:0]   target_len_i,
   input  logic [MAX_SYM-1:0] target_code_i,
   morse_decoder_if.master    char_if,
   output logic [7:0]         score_o,
   output logic               overflow_o
);
   localparam logic [CNT_W-1:0] TMAX    = '1;
   localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(CHAR_GAP - 1);
   localparam logic [CNT_W:0]   DOT_D   = (CNT_W + 1)'(DOT_MIN);
   localparam logic [CNT_W:0]   DASH_D  = (CNT_W + 1)'(DASH_MIN);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_SYM);

   logic key_d, rise, fall;

   morse_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .key_i   (key_i),
      .key_d_o (key_d),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d, timer_inc;
   logic [CNT_W:0]     dur;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_SYM-1:0] code_q, code_d;
   logic               err_q, err_d;
   logic               emit, sym, new_match;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      len_d     = len_q;
      code_d    = code_q;
      err_d     = err_q;
      emit      = 1'b0;
      sym       = DOT;
      timer_inc = (timer_q == TMAX) ? timer_q : timer_q + CNT_W'(1);
      dur       = {1'b0, timer_q} + (CNT_W + 1)'(1);
      unique case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_MARK;
               timer_d = '0;
               len_d   = '0;
               code_d  = '0;
               err_d   = 1'b0;
            end
         end
         S_MARK: begin
            timer_d = timer_inc;
            if (fall) begin
               // Marks shorter than a dot are glitches and leave the character untouched.
               if (dur >= DOT_D) begin
                  sym = (dur >= DASH_D) ? DASH : DOT;
                  if (len_q == LEN_MAX) begin
                     err_d = 1'b1;
                  end else begin
                     code_d = {code_q[MAX_SYM-2:0], sym};
                     len_d  = len_q + LEN_W'(1);
                  end
               end
               state_d = (len_d != '0) ? S_SPACE : S_IDLE;
               timer_d = '0;
            end else if (timer_q == TMAX) begin
               state_d = S_STUCK;
            end
         end
         S_SPACE: begin
            timer_d = timer_inc;
            if (rise) begin
               state_d = S_MARK;
               timer_d = '0;
            end else if (timer_q == GAP_T) begin
               emit    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_STUCK: begin
            if (fall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (!en_i) begin
         state_d = S_IDLE;
         emit    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         len_q   <= '0;
         code_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         len_q   <= len_d;
         code_q  <= code_d;
         err_q   <= err_d;
      end
   end

   logic               valid_q, herr_q, match_q, ovf_q, accept;
   logic [LEN_W-1:0]   hlen_q;
   logic [MAX_SYM-1:0] hcode_q;
   logic [7:0]         score_q;

   assign accept    = valid_q & char_if.char_ready;
   assign new_match = !err_q && (len_q == target_len_i) && (code_q == target_code_i);

   // An accept on the same edge frees the slot, so the new character loads without a bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         hlen_q  <= '0;
         hcode_q <= '0;
         herr_q  <= 1'b0;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
         score_q <= '0;
      end else begin
         if (emit && (!valid_q || accept)) begin
            valid_q <= 1'b1;
            hlen_q  <= len_q;
            hcode_q <= code_q;
            herr_q  <= err_q;
            match_q <= new_match;
         end else if (emit) begin
            ovf_q <= 1'b1;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
         if (accept && match_q && (score_q != 8'hFF)) score_q <= score_q + 8'd1;
      end
   end

   assign char_if.char_valid = valid_q;
   assign char_if.char_len   = hlen_q;
   assign char_if.char_code  = hcode_q;
   assign char_if.char_err   = herr_q;
   assign char_if.match      = match_q;
   assign score_o            = score_q;
   assign overflow_o         = ovf_q;
endmodule

// File: tb/tb_morse_decoder.sv
// Directed and randomized checks of morse_decoder against a mark-duration reference model.
module tb_morse_decoder;
   import morse_pkg::*;

   localparam int MAX_SYM = 5;
   localparam int LEN_W   = len_w(MAX_SYM);

   logic               clk = 1'b0;
   logic               rst_n, en, key, ready;
   logic [LEN_W-1:0]   tlen;
   logic [MAX_SYM-1:0] tcode;
   logic [7:0]         score;
   logic               ovf;

   int checks = 0;
   int errors = 0;
   int marks[$];
   int sc_exp = 0;
   int lat;

   always #5 clk = ~clk;

   morse_decoder_if #(.LEN_W(LEN_W), .MAX_SYM(MAX_SYM)) cif ();
   assign cif.char_ready = ready;

   morse_decoder dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .en_i          (en),
      .key_i         (key),
      .target_len_i  (tlen),
      .target_code_i (tcode),
      .char_if       (cif),
      .score_o       (score),
      .overflow_o    (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: marks below 20 cycles vanish, below 60 are dots, the rest dashes;
   // the character keeps its first five symbols and flags anything longer.
   task automatic model(output int elen, output int ecode, output bit eerr);
      int syms[$];
      foreach (marks[i]) if (marks[i] >= 20) syms.push_back(marks[i] >= 60 ? 1 : 0);
      elen  = (syms.size() > MAX_SYM) ? MAX_SYM : syms.size();
      eerr  = syms.size() > MAX_SYM;
      ecode = 0;
      for (int i = 0; i < elen; i++) ecode += syms[i] << (elen - 1 - i);
   endtask

   task automatic play(input int gap);
      foreach (marks[i]) begin
         key = 1'b1;
         repeat (marks[i]) tick();
         key = 1'b0;
         if (i != marks.size() - 1) repeat (gap) tick();
      end
   endtask

   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (cif.char_valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      check({tag, ".valid"}, cif.char_valid, 1);
   endtask

   task automatic accept(input bit m);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      if (m && sc_exp < 255) sc_exp++;
      check("accept.score", score, sc_exp);
      check("accept.valid", cif.char_valid, 0);
   endtask

   task automatic run_char(input string tag, input int gap, input bit tgt_model,
                           input int tl, input int tc, input bit do_accept);
      int elen, ecode, n;
      bit eerr, ematch;
      model(elen, ecode, eerr);
      if (tgt_model) begin
         tl = elen;
         tc = ecode;
      end
      tlen  = LEN_W'(tl);
      tcode = MAX_SYM'(tc);
      play(gap);
      wait_valid(tag, n);
      ematch = !eerr && (elen == tl) && (ecode == tc);
      check({tag, ".len"}, cif.char_len, elen);
      check({tag, ".code"}, cif.char_code, ecode);
      check({tag, ".err"}, cif.char_err, eerr);
      check({tag, ".match"}, cif.match, ematch);
      $display("char %s: len=%0d code=%05b err=%0d match=%0d", tag, elen, ecode[4:0], eerr, ematch);
      if (do_accept) accept(ematch);
   endtask

   initial begin
      int n, k, g;
      rst_n = 1'b0; en = 1'b1; key = 1'b1; ready = 1'b0; tlen = '0; tcode = '0;
      repeat (3) tick();
      check("rst.valid", cif.char_valid, 0);
      check("rst.len", cif.char_len, 0);
      check("rst.code", cif.char_code, 0);
      check("rst.err", cif.char_err, 0);
      check("rst.match", cif.match, 0);
      check("rst.score", score, 0);
      check("rst.ovf", ovf, 0);
      rst_n = 1'b1;
      repeat (300) tick();
      key = 1'b0;
      repeat (100) tick();
      check("held_key.no_valid", cif.char_valid, 0);

      marks = '{30, 70};              run_char("A", 15, 0, 2, 1, 1);
      marks = '{30, 5};               run_char("E_glitch", 10, 0, 1, 0, 1);
      marks = '{19, 20, 59, 60};      run_char("bounds", 15, 1, 0, 0, 1);
      marks = '{70, 70, 70, 70, 70};  run_char("zero", 15, 0, 5, 31, 1);
      marks = '{30, 30, 30, 30, 30, 30}; run_char("six_dots", 15, 0, 5, 0, 1);

      for (int r = 0; r < 10; r++) begin
         marks.delete();
         k = $urandom_range(1, 6);
         for (int s = 0; s < k; s++) begin
            if ($urandom_range(0, 4) == 0) marks.push_back($urandom_range(3, 15));
            marks.push_back($urandom_range(0, 1) ? $urandom_range(64, 200) : $urandom_range(22, 55));
         end
         g = $urandom_range(8, 25);
         run_char($sformatf("rand%0d", r), g, bit'($urandom_range(0, 1)),
                  $urandom_range(0, 5), $urandom_range(0, 31), 1);
      end

      // Accept the held 'T' on exactly the edge that loads the next 'E'.
      marks = '{70}; tlen = 1; tcode = 1;
      play(15);
      wait_valid("ovl_T", lat);
      marks = '{30}; tlen = 1; tcode = 0;
      play(15);
      repeat (lat - 1) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      sc_exp++;
      check("ovl.valid", cif.char_valid, 1);
      check("ovl.len", cif.char_len, 1);
      check("ovl.code", cif.char_code, 0);
      check("ovl.match", cif.match, 1);
      check("ovl.ovf", ovf, 0);
      check("ovl.score", score, sc_exp);
      $display("overlap: latency=%0d", lat);
      accept(1);

      marks = '{70}; run_char("bp_T", 15, 0, 1, 1, 0);
      marks = '{30};
      tlen = 1; tcode = 0;
      play(15);
      repeat (100) tick();
      check("bp.valid", cif.char_valid, 1);
      check("bp.len", cif.char_len, 1);
      check("bp.code", cif.char_code, 1);
      check("bp.ovf", ovf, 1);
      tlen = 3; tcode = 5'b10101;
      tick();
      check("bp.match_stable", cif.match, 1);
      accept(1);

      key = 1'b1;
      repeat (300) tick();
      key = 1'b0;
      repeat (100) tick();
      check("stuck.no_valid", cif.char_valid, 0);
      marks = '{70}; run_char("T_after_stuck", 15, 0, 1, 1, 1);

      marks = '{30};
      play(15);
      repeat (10) tick();
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1;
      repeat (100) tick();
      check("en_low.no_valid", cif.char_valid, 0);
      check("en_low.score", score, sc_exp);
      check("en_low.ovf", ovf, 1);

      key = 1'b1;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst.score", score, 0);
      check("async_rst.ovf", ovf, 0);
      check("async_rst.valid", cif.char_valid, 0);
      key = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (100) tick();
      check("after_rst.no_valid", cif.char_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
